// File: rtl/reg_write_serializer_pkg.sv
// ============================================================================
// reg_file_pkg : shared types and decode helper for the register write path
// Revision     : 1.0
// ============================================================================
`default_nettype none

package reg_file_pkg;

  localparam int NUM_REGS_DEFAULT = 16;
  localparam int MAX_REGS         = 64;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Address 0 maps to the MSB of the NUM_REGS-wide enable; out-of-range gives zero.
  function automatic logic [MAX_REGS-1:0] addr_to_onehot(input int addr, input int num_regs);
    logic [MAX_REGS-1:0] result;
    result = '0;
    for (int i = 0; i < MAX_REGS; i++) begin
      result[i[5:0]] = (i < num_regs) && (addr == num_regs - 1 - i);
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_write_serializer_if.sv
// ============================================================================
// reg_wr_if : two-source writeback request bus (A = ALU, B = load)
// Revision  : 1.0
// ============================================================================
`default_nettype none

interface reg_wr_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready
  );
endinterface

`default_nettype wire

// File: rtl/reg_write_serializer_decoder.sv
// ============================================================================
// reg_onehot_decoder : gated MSB-first address-to-one-hot decode
// Revision           : 1.0
// ============================================================================
`default_nettype none

module reg_onehot_decoder
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEFAULT,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  wire logic [ADDR_W-1:0]   addr_i,
  input  wire logic                en_i,
  output logic      [NUM_REGS-1:0] onehot_o
);

  logic [MAX_REGS-1:0] w_full;

  assign w_full   = addr_to_onehot(int'(addr_i), NUM_REGS);
  assign onehot_o = en_i ? w_full[NUM_REGS-1:0] : '0;

  // Bits above NUM_REGS are always zero from the helper.
  generate
    if (NUM_REGS < MAX_REGS) begin : g_pad
      logic w_unused_hi;
      assign w_unused_hi = ^w_full[MAX_REGS-1:NUM_REGS];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/reg_write_serializer.sv
// ============================================================================
// reg_write_serializer : merges ALU (A, priority) and load (B) writebacks
//                        onto one register-file write port
// Revision             : 1.0
// ============================================================================
`default_nettype none

module reg_write_serializer
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS           = NUM_REGS_DEFAULT,
  parameter int ADDR_W             = $clog2(NUM_REGS),
  parameter int DATA_W             = 32,
  parameter int ZERO_REG_HARDWIRED = 0
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  input  wire logic                load_enable_i,
  reg_wr_if.slave                  wr_if,
  output logic      [NUM_REGS-1:0] load_en_o,
  output logic      [DATA_W-1:0]   wr_data_o,
  output logic                     drop_b_o,
  output logic                     bad_addr_o
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              drop_d;

  logic                w_ready;
  logic                w_a_acc;
  logic                w_b_acc;
  logic                w_issue;
  logic [ADDR_W-1:0]   w_iss_addr;
  logic [DATA_W-1:0]   w_iss_data;
  logic                w_dec_en;
  logic                w_bad;
  logic [NUM_REGS-1:0] w_onehot;

  assign w_ready       = load_enable_i && (state_q == IDLE);
  assign wr_if.a_ready = w_ready;
  assign wr_if.b_ready = w_ready;
  assign w_a_acc       = wr_if.a_valid && w_ready;
  assign w_b_acc       = wr_if.b_valid && w_ready;

  always_comb begin
    state_d     = state_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    drop_d      = 1'b0;
    w_issue     = 1'b0;
    w_iss_addr  = '0;
    w_iss_data  = '0;
    case (state_q)
      IDLE: begin
        if (w_a_acc) begin
          w_issue    = 1'b1;
          w_iss_addr = wr_if.a_addr;
          w_iss_data = wr_if.a_data;
          if (w_b_acc) begin
            // A would overwrite B in the same register, so B is redundant.
            if (wr_if.b_addr == wr_if.a_addr) begin
              drop_d = 1'b1;
            end else begin
              hold_addr_d = wr_if.b_addr;
              hold_data_d = wr_if.b_data;
              state_d     = HOLD;
            end
          end
        end else if (w_b_acc) begin
          w_issue    = 1'b1;
          w_iss_addr = wr_if.b_addr;
          w_iss_data = wr_if.b_data;
        end
      end
      HOLD: begin
        if (load_enable_i) begin
          w_issue    = 1'b1;
          w_iss_addr = hold_addr_q;
          w_iss_data = hold_data_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign w_bad    = w_issue && (int'(w_iss_addr) >= NUM_REGS);
  assign w_dec_en = w_issue && !((ZERO_REG_HARDWIRED != 0) && (w_iss_addr == '0));

  reg_onehot_decoder #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_dec (
    .addr_i   (w_iss_addr),
    .en_i     (w_dec_en),
    .onehot_o (w_onehot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      load_en_o   <= '0;
      wr_data_o   <= '0;
      drop_b_o    <= 1'b0;
      bad_addr_o  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      load_en_o   <= w_onehot;
      drop_b_o    <= drop_d;
      bad_addr_o  <= w_bad;
      if (w_issue) begin
        wr_data_o <= w_iss_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_write_serializer.sv
// ============================================================================
// tb_reg_write_serializer : directed + random check of reg_write_serializer
// Revision                : 1.0
// ============================================================================
`default_nettype none

module tb_reg_write_serializer;

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic le16  = 1'b0;
  logic le12  = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  wr_t         q16[$];
  logic [31:0] m_wd16 = '0;

  reg_wr_if #(.ADDR_W(4), .DATA_W(32)) if16 ();
  reg_wr_if #(.ADDR_W(4), .DATA_W(32)) if12 ();

  logic [15:0] load_en16;
  logic [31:0] wd16;
  logic        drop16, bad16;
  logic [11:0] load_en12;
  logic [31:0] wd12;
  logic        drop12, bad12;

  reg_write_serializer #(
    .NUM_REGS(16), .ADDR_W(4), .DATA_W(32), .ZERO_REG_HARDWIRED(0)
  ) u_dut16 (
    .clk(clk), .rst_n(rst_n), .load_enable_i(le16), .wr_if(if16),
    .load_en_o(load_en16), .wr_data_o(wd16), .drop_b_o(drop16), .bad_addr_o(bad16)
  );

  reg_write_serializer #(
    .NUM_REGS(12), .ADDR_W(4), .DATA_W(32), .ZERO_REG_HARDWIRED(1)
  ) u_dut12 (
    .clk(clk), .rst_n(rst_n), .load_enable_i(le12), .wr_if(if12),
    .load_en_o(load_en12), .wr_data_o(wd12), .drop_b_o(drop12), .bad_addr_o(bad12)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_onehot(input int addr, input int num, input bit zero);
    if (addr >= num || (zero && addr == 0)) return 64'd0;
    return 64'd1 << (num - 1 - addr);
  endfunction

  // Reference model: at most one queued B write, which blocks new requests.
  task automatic step16();
    logic        rdy;
    logic [15:0] e_le;
    logic        e_drop;
    wr_t         w;
    #1;
    rdy = le16 && (q16.size() == 0);
    check("a_ready16", 64'(if16.a_ready), 64'(rdy));
    check("b_ready16", 64'(if16.b_ready), 64'(rdy));
    e_le   = '0;
    e_drop = 1'b0;
    if (q16.size() != 0) begin
      if (le16) begin
        w      = q16.pop_front();
        e_le   = 16'(exp_onehot(int'(w.addr), 16, 1'b0));
        m_wd16 = w.data;
      end
    end else if (rdy) begin
      if (if16.a_valid) begin
        e_le   = 16'(exp_onehot(int'(if16.a_addr), 16, 1'b0));
        m_wd16 = if16.a_data;
        if (if16.b_valid) begin
          if (if16.b_addr == if16.a_addr) e_drop = 1'b1;
          else q16.push_back('{addr: if16.b_addr, data: if16.b_data});
        end
      end else if (if16.b_valid) begin
        e_le   = 16'(exp_onehot(int'(if16.b_addr), 16, 1'b0));
        m_wd16 = if16.b_data;
      end
    end
    @(posedge clk);
    #1;
    check("load_en16", 64'(load_en16), 64'(e_le));
    check("wr_data16", 64'(wd16), 64'(m_wd16));
    check("drop_b16", 64'(drop16), 64'(e_drop));
    check("bad_addr16", 64'(bad16), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_load_en16", 64'(load_en16), 64'd0);
    check("rst_wr_data16", 64'(wd16), 64'd0);
    check("rst_drop16", 64'(drop16), 64'd0);
    check("rst_bad16", 64'(bad16), 64'd0);
    check("rst_load_en12", 64'(load_en12), 64'd0);
    check("rst_wr_data12", 64'(wd12), 64'd0);
    q16.delete();
    m_wd16 = '0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic set16(input logic av, input logic [3:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [3:0] ba, input logic [31:0] bd);
    if16.a_valid = av; if16.a_addr = aa; if16.a_data = ad;
    if16.b_valid = bv; if16.b_addr = ba; if16.b_data = bd;
  endtask

  task automatic cyc12(input logic [3:0] addr, input logic [31:0] data);
    if12.a_valid = 1'b1; if12.a_addr = addr; if12.a_data = data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    set16(1'b1, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    if12.a_valid = 1'b0; if12.a_addr = '0; if12.a_data = '0;
    if12.b_valid = 1'b0; if12.b_addr = '0; if12.b_data = '0;
    #2;
    check("init_load_en16", 64'(load_en16), 64'd0);
    check("init_a_ready16", 64'(if16.a_ready), 64'd0);
    check("init_a_ready12", 64'(if12.a_ready), 64'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step16();

    // Single A write, then idle cycle where wr_data must hold.
    le16 = 1'b1;
    set16(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'h0);
    step16();
    check("single_a_onehot", 64'(load_en16), 64'h1000);
    set16(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    step16();
    check("single_a_hold_data", 64'(wd16), 64'hDEADBEEF);

    // Different-address pair: A now, B from the hold buffer next.
    set16(1'b1, 4'd2, 32'h11, 1'b1, 4'd9, 32'h22);
    step16();
    check("pair_a_onehot", 64'(load_en16), 64'h2000);
    set16(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    step16();
    check("pair_b_onehot", 64'(load_en16), 64'h0040);
    check("pair_b_data", 64'(wd16), 64'h22);
    step16();

    // Same-address collision.
    set16(1'b1, 4'd5, 32'hAA, 1'b1, 4'd5, 32'hBB);
    step16();
    check("coll_onehot", 64'(load_en16), 64'h0400);
    check("coll_drop", 64'(drop16), 64'd1);
    set16(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    step16();

    // Stall in HOLD for three cycles.
    set16(1'b1, 4'd1, 32'h33, 1'b1, 4'd14, 32'h44);
    step16();
    set16(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    le16 = 1'b0;
    for (int i = 0; i < 3; i++) step16();
    le16 = 1'b1;
    step16();
    check("stall_release", 64'(load_en16), 64'h0002);

    // Reset while a write is held: it must never issue.
    set16(1'b1, 4'd7, 32'h55, 1'b1, 4'd8, 32'h66);
    step16();
    do_reset();
    set16(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    step16();
    step16();

    // Random traffic with frequent collisions and stalls.
    for (int n = 0; n < 400; n++) begin
      le16         = ($urandom_range(0, 3) != 0);
      if16.a_valid = 1'($urandom_range(0, 1));
      if16.a_addr  = 4'($urandom_range(0, 15));
      if16.a_data  = $urandom;
      if16.b_valid = 1'($urandom_range(0, 1));
      if16.b_addr  = ($urandom_range(0, 3) == 0) ? if16.a_addr : 4'($urandom_range(0, 15));
      if16.b_data  = $urandom;
      step16();
    end
    le16 = 1'b0;
    set16(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);

    // NUM_REGS=12 with hardwired R0.
    le12 = 1'b1;
    cyc12(4'd0, 32'h0BAD0000);
    check("r0_load_en12", 64'(load_en12), 64'd0);
    check("r0_bad12", 64'(bad12), 64'd0);
    check("r0_wr_data12", 64'(wd12), 64'h0BAD0000);
    cyc12(4'd13, 32'h13131313);
    check("oor_load_en12", 64'(load_en12), 64'd0);
    check("oor_bad12", 64'(bad12), 64'd1);
    cyc12(4'd11, 32'h11111111);
    check("r11_load_en12", 64'(load_en12), 64'h001);
    check("r11_bad12", 64'(bad12), 64'd0);
    check("r11_wr_data12", 64'(wd12), 64'h11111111);
    if12.b_valid = 1'b1; if12.b_addr = 4'd13; if12.b_data = 32'h77;
    cyc12(4'd10, 32'h10);
    check("hold12_a", 64'(load_en12), 64'h002);
    if12.b_valid = 1'b0;
    if12.a_valid = 1'b0;
    #1;
    check("hold12_ready", 64'(if12.a_ready), 64'd0);
    @(posedge clk);
    #1;
    check("hold12_b_load_en", 64'(load_en12), 64'd0);
    check("hold12_b_bad", 64'(bad12), 64'd1);
    check("hold12_b_data", 64'(wd12), 64'h77);
    check("hold12_drop", 64'(drop12), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_write_serializer.md
Name: reg_write_serializer

Overview:
Merges two register-file writeback sources into the register file's single write port. Port A carries ALU writeback and has priority; port B carries load writeback. Each accepted write address is decoded into a registered one-hot load-enable vector and paired with its data. The block adds a parametrised register count, a valid/ready handshake, a one-entry hold buffer for port B, same-address collision handling and optional hardwired-zero R0 suppression.

Parameters:
NUM_REGS, 16, number of architectural registers and width of load_en.
ADDR_W, $clog2(NUM_REGS), write address width.
DATA_W, 32, write data width.
ZERO_REG_HARDWIRED, 0, when 1 a write to address 0 is accepted but produces no load enable.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
load_enable  in  1  global write enable; when low, no new request is accepted and any held write stays held.
a_valid  in  1  port A request valid.
a_ready  out  1  port A ready; combinational.
a_addr  in  ADDR_W  port A destination register.
a_data  in  DATA_W  port A write data.
b_valid  in  1  port B request valid.
b_ready  out  1  port B ready; combinational.
b_addr  in  ADDR_W  port B destination register.
b_data  in  DATA_W  port B write data.
load_en  out  NUM_REGS  registered one-hot register load enable.
wr_data  out  DATA_W  registered write data that accompanies load_en.
drop_b  out  1  one-cycle pulse: a port B write was discarded because port A wrote the same register.
bad_addr  out  1  one-cycle pulse: an issued write had an address >= NUM_REGS.

Behaviour:
- Reset (asynchronous, rst_n low): load_en=0, wr_data=0, drop_b=0, bad_addr=0, state=IDLE, hold buffer empty. A write held when reset asserts is lost.
- State machine has two states.
  - IDLE: hold buffer empty.
  - HOLD: buffer contains one port B write (address and data).
- Handshake:
  - a_ready = b_ready = load_enable && (state==IDLE).
  - A request is accepted when valid && ready in the same cycle.
- Latency: an issued write appears on load_en/wr_data exactly 1 cycle after acceptance (or after issue from HOLD).
- load_en is a pulse vector and is all-zero in any cycle with no issue. wr_data keeps its last value when nothing is issued.
- Decode: address k sets load_en bit NUM_REGS-1-k. This matches the existing register-file load-enable ordering: address 0 maps to the MSB.
- IDLE, only A accepted: issue A, stay in IDLE.
- IDLE, only B accepted: issue B, stay in IDLE.
- IDLE, both accepted, a_addr != b_addr:
  - Issue A next cycle.
  - Capture b_addr/b_data into the hold buffer; state becomes HOLD.
- IDLE, both accepted, a_addr == b_addr:
  - Issue A and discard B; pulse drop_b in the same cycle A appears on load_en.
  - Stay in IDLE.
- HOLD with load_enable=1: issue the held write next cycle, empty the buffer, return to IDLE. Ready is low during this cycle, so no new request is accepted.
- HOLD with load_enable=0: remain in HOLD, issue nothing.
- IDLE with load_enable=0: ready is low, nothing is accepted, load_en=0.
- ZERO_REG_HARDWIRED=1 and issued address 0: load_en all-zero; still counts as an issue for sequencing.
- Issued address >= NUM_REGS (only possible when NUM_REGS is not a power of two): load_en all-zero and bad_addr pulses alongside the would-be write.
- Collision detection uses the full ADDR_W address, including invalid addresses.

Decomposition:
- Shared package reg_file_pkg:
  - NUM_REGS default.
  - State enum {IDLE, HOLD}.
  - Function addr_to_onehot(addr), MSB-first, returning zero for out-of-range addresses.
- One natural sub-module: reg_onehot_decoder, parametrised NUM_REGS/ADDR_W, combinational, with an enable input. It is instantiated once on the issue path, ahead of the output register.

Test Plan:
- Reset: drive rst_n low mid-cycle with a_valid=1 -> all outputs 0 immediately (asynchronous), a_ready=0 while load_enable=0.
- Single A write: load_enable=1, a_valid=1, a_addr=3, a_data=0xDEADBEEF -> next cycle load_en=16'h1000, wr_data=0xDEADBEEF; the cycle after, load_en=0 and wr_data holds.
- Both ports, different addresses: A addr=2 data=0x11, B addr=9 data=0x22 -> cycle+1 load_en=16'h2000/data 0x11; a_ready=b_ready=0 during HOLD; cycle+2 load_en=16'h0040/data 0x22; ready is 1 again at cycle+2.
- Same-address collision: A and B both addr=5, data 0xAA/0xBB -> cycle+1 load_en=16'h0400, wr_data=0xAA, drop_b=1; no HOLD entered, ready stays 1.
- Stall in HOLD: after a different-address capture, drop load_enable for 3 cycles -> load_en=0 throughout; held write issues 1 cycle after load_enable returns to 1. A second run asserts rst_n low during HOLD -> held write never issues.
- Parameter variants: NUM_REGS=12, ZERO_REG_HARDWIRED=1. addr 0 -> load_en=0, no bad_addr. addr 13 -> load_en=0, bad_addr=1. addr 11 -> load_en=12'h001.
